// File: rtl/ysyx_24100029_rr_arb4_if.sv
// Handshake bundle between four requesters, the round-robin arbiter and the
// shared downstream port. The arbiter connects through the slave modport;
// the requester/downstream side (or a testbench) uses the master modport.
// Optional per-port grant counters appear only when ARB_PERF_CNT_EN is defined.
interface ysyx_24100029_rr_arb4_if #(
   parameter logic Is_One_Hot = 1'b1,
   parameter int   CNT_WIDTH  = 16
);
   localparam int SEL_WIDTH = Is_One_Hot ? 4 : 2;

   logic [3:0]           req_valid_i;
   logic [3:0]           req_ready_o;
   logic                 down_valid_o;
   logic                 down_ready_i;
   logic                 resp_valid_i;
   logic                 resp_ready_i;
   logic [3:0]           resp_valid_o;
   logic [SEL_WIDTH-1:0] sel_o;
   logic [1:0]           grant_idx_o;
   logic                 busy_o;
`ifdef ARB_PERF_CNT_EN
   logic [4*CNT_WIDTH-1:0] grant_cnt_o;
`endif

   modport master (
      output req_valid_i, down_ready_i, resp_valid_i, resp_ready_i,
      input  req_ready_o, down_valid_o, resp_valid_o, sel_o, grant_idx_o, busy_o
`ifdef ARB_PERF_CNT_EN
      , input grant_cnt_o
`endif
   );

   modport slave (
      input  req_valid_i, down_ready_i, resp_valid_i, resp_ready_i,
      output req_ready_o, down_valid_o, resp_valid_o, sel_o, grant_idx_o, busy_o
`ifdef ARB_PERF_CNT_EN
      , output grant_cnt_o
`endif
   );
endinterface

// File: rtl/ysyx_24100029_rr_arb4.sv
// Four-way round-robin arbiter in front of a shared memory/bus port.
// A grant is held from request acceptance until the response completes, so
// the registered select steers both request and response paths. The search
// for the next grant starts one past the last requester that completed.
// Optional feature: define ARB_PERF_CNT_EN for saturating per-port grant
// counters on grant_cnt_o.
module ysyx_24100029_rr_arb4 #(
   parameter logic Is_One_Hot = 1'b1,
   parameter int   CNT_WIDTH  = 16,
   localparam int  SEL_WIDTH  = Is_One_Hot ? 4 : 2
) (
   input logic                     clk,
   input logic                     rst_n,
   ysyx_24100029_rr_arb4_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      GRANT     = 2'd1,
      WAIT_RESP = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [1:0]           ptr_q, ptr_d;
   logic [1:0]           grant_q, grant_d;
   logic [SEL_WIDTH-1:0] sel_q, sel_d;
   logic                 down_valid;
   logic [3:0]           req_ready;
   logic [3:0]           resp_valid;
   logic                 req_hs;

   // First asserted request searching ptr, ptr+1, ... with 2-bit wrap.
   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [1:0] idx;
      rr_pick = ptr;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (req[idx]) rr_pick = idx;
      end
   endfunction

   // Mux select encoding for a grant index.
   function automatic logic [SEL_WIDTH-1:0] encode_sel(input logic [1:0] idx);
      if (Is_One_Hot) encode_sel = SEL_WIDTH'(4'b0001 << idx);
      else            encode_sel = SEL_WIDTH'(idx);
   endfunction

   // State, pointer, grant index and select registers.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         grant_q <= 2'd0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
      end
   end

   // Next-state logic and handshake steering for the current grant.
   // NOTE: every signal gets a default first, so no path leaves a value
   // unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_d    = grant_q;
      sel_d      = sel_q;
      down_valid = 1'b0;
      req_ready  = 4'b0000;
      resp_valid = 4'b0000;
      req_hs     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|bus.req_valid_i) begin
               grant_d = rr_pick(bus.req_valid_i, ptr_q);
               sel_d   = encode_sel(grant_d);
               state_d = GRANT;
            end
         end
         GRANT: begin
            down_valid         = bus.req_valid_i[grant_q];
            req_ready[grant_q] = bus.down_ready_i;
            if (down_valid && bus.down_ready_i) begin
               req_hs  = 1'b1;
               state_d = WAIT_RESP;
            end else if (!bus.req_valid_i[grant_q]) begin
               // Withdrawn request: rearbitrate without advancing the pointer.
               state_d = IDLE;
            end
         end
         WAIT_RESP: begin
            resp_valid[grant_q] = bus.resp_valid_i;
            if (bus.resp_valid_i && bus.resp_ready_i) begin
               state_d = IDLE;
               ptr_d   = grant_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.down_valid_o = down_valid;
   assign bus.req_ready_o  = req_ready;
   assign bus.resp_valid_o = resp_valid;
   assign bus.sel_o        = sel_q;
   assign bus.grant_idx_o  = grant_q;
   assign bus.busy_o       = (state_q != IDLE);

`ifdef ARB_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] cnt_q [4];

   // Saturating per-port counters of accepted request handshakes.
   // NOTE: this small register array is reset explicitly because the counters
   // must read zero after reset; large data memories would normally not be.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else if (req_hs && (cnt_q[grant_q] != '1)) begin
         cnt_q[grant_q] <= cnt_q[grant_q] + CNT_WIDTH'(1);
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_cnt_out
      assign bus.grant_cnt_o[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
   end
`endif

endmodule
